vga_scanout: RTL and testbench

//  Reads the 160x120 3-bit pixel memory that the screen-display logic writes
//  ({y,x} addressing). Scans it out as 640x480@60 Hz VGA, scaling each pixel 4x4.

---
 rtl/vga_scanout.sv | 141 ++++++++++++++
 tb/tb_vga_scanout.sv | 118 +++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: scans a 160x120 3-bit pixel RAM out as 640x480@60 VGA with 4x4 scaling, 2-tick pipeline.
// Optional colour-bar source selected by TEST_MODE when VGA_TEST_PATTERN_EN is defined.
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  output logic [14:0] MEM_ADDR,
  input  logic [2:0]  MEM_DATA,
  input  logic        TEST_MODE,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        FRAME_START
);

  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic        phase_q;
  logic        tick;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;

  logic        s1_vis_d, s1_hs_d, s1_vs_d, s1_first_d;
  logic [14:0] s1_addr_d;
  logic        s1_vis_q, s1_hs_q, s1_vs_q, s1_first_q;
  logic [14:0] s1_addr_q;

  logic [2:0]  pix_d;
  logic [2:0]  rgb_q;
  logic        hs_q, vs_q, blank_q, fs_q;

  // Every second CLOCK_50 is a pixel tick; state advances only then.
  assign tick = phase_q;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_LAST) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
    end
  end

  always_comb begin
    s1_vis_d   = (hcount_q < H_ACT) && (vcount_q < V_ACT);
    s1_hs_d    = !((hcount_q >= HS_START) && (hcount_q < HS_END));
    s1_vs_d    = !((vcount_q >= VS_START) && (vcount_q < VS_END));
    s1_first_d = (hcount_q == '0) && (vcount_q == '0);
    s1_addr_d  = s1_vis_d ? {vcount_q[8:2], hcount_q[9:2]} : '0;
  end

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] s1_bar_d, s1_bar_q;

  // Eight equal-width bars across the visible line, bar 0 black.
  always_comb begin
    s1_bar_d = '0;
    for (int i = 1; i < 8; i++) begin
      if (hcount_q >= 10'(i * (H_ACTIVE / 8))) s1_bar_d = 3'(i);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) s1_bar_q <= '0;
    else if (tick) s1_bar_q <= s1_bar_d;
  end

  assign pix_d = TEST_MODE ? s1_bar_q : MEM_DATA;
`else
  logic test_mode_unused;
  assign test_mode_unused = TEST_MODE;
  assign pix_d = MEM_DATA;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      phase_q    <= 1'b0;
      hcount_q   <= '0;
      vcount_q   <= '0;
      s1_vis_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s1_first_q <= 1'b0;
      s1_addr_q  <= '0;
      rgb_q      <= '0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      blank_q    <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      phase_q <= ~phase_q;
      fs_q    <= 1'b0;
      if (tick) begin
        hcount_q   <= hcount_d;
        vcount_q   <= vcount_d;
        s1_vis_q   <= s1_vis_d;
        s1_hs_q    <= s1_hs_d;
        s1_vs_q    <= s1_vs_d;
        s1_first_q <= s1_first_d;
        s1_addr_q  <= s1_addr_d;
        rgb_q      <= s1_vis_q ? pix_d : 3'b000;
        hs_q       <= s1_hs_q;
        vs_q       <= s1_vs_q;
        blank_q    <= s1_vis_q;
        fs_q       <= s1_first_q;
      end
    end
  end

  assign MEM_ADDR    = s1_addr_q;
  assign VGA_R       = {8{rgb_q[2]}};
  assign VGA_G       = {8{rgb_q[1]}};
  assign VGA_B       = {8{rgb_q[0]}};
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_q;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = phase_q;
  assign FRAME_START = fs_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Randomised bench for vga_scanout; the vertical timing is shortened so whole frames fit in a short run.
module tb_vga_scanout;

  localparam int H_TOT   = 800;
  localparam int V_ACT   = 8;
  localparam int V_FPL   = 2;
  localparam int V_SYL   = 2;
  localparam int V_BPL   = 3;
  localparam int V_TOT   = V_ACT + V_FPL + V_SYL + V_BPL;
  localparam int FRAME_T = H_TOT * V_TOT;

  logic        CLOCK_50 = 1'b0;
  logic        RESET = 1'b1;
  logic [14:0] MEM_ADDR;
  logic [2:0]  MEM_DATA = 3'b000;
  logic        TEST_MODE = 1'b0;
  logic [7:0]  VGA_R, VGA_G, VGA_B;
  logic        VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK, FRAME_START;

  vga_scanout #(.V_ACTIVE(V_ACT), .V_FP(V_FPL), .V_SYNC(V_SYL), .V_BP(V_BPL)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA),
    .TEST_MODE(TEST_MODE), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_SYNC_N(VGA_SYNC_N), .VGA_CLK(VGA_CLK), .FRAME_START(FRAME_START)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  logic [2:0] mem [0:32767];
  int checks = 0;
  int errors = 0;
  int n = 0;
  int fs_seen = 0;
  logic rst_edge;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  function automatic bit visible(input int p);
    return ((p % H_TOT) < 640) && (((p / H_TOT) % V_TOT) < V_ACT);
  endfunction

  // Pixel position p maps to RAM word (line/4)*256 + column/4.
  function automatic int addr_of(input int p);
    int h, v;
    h = p % H_TOT;
    v = (p / H_TOT) % V_TOT;
    return visible(p) ? ((v / 4) * 256 + h / 4) : 0;
  endfunction

  function automatic logic [2:0] colour_of(input int p);
`ifdef VGA_TEST_PATTERN_EN
    if (TEST_MODE) return 3'((p % H_TOT) / 80);
`endif
    return mem[addr_of(p)];
  endfunction

  // One CLOCK_50: count the edge, act as a 1-cycle-latency RAM that drives garbage
  // while no tick is due, then check every output against the timing model.
  task automatic step();
    logic [2:0] c;
    int k, h, v;
    bit vis;
    @(posedge CLOCK_50);
    rst_edge = RESET;
    if (rst_edge) n = 0; else n++;
    #1;
    if (!rst_edge && (n % 2 == 1)) MEM_DATA = mem[MEM_ADDR];
    else MEM_DATA = 3'($urandom);
    @(negedge CLOCK_50);
    if (FRAME_START === 1'b1) fs_seen++;
    chk("vga_clk", 32'(VGA_CLK), rst_edge ? 32'd0 : 32'(n % 2));
    chk("mem_addr", 32'(MEM_ADDR), (rst_edge || n < 2) ? 32'd0 : 32'(addr_of((n - 2) / 2)));
    if (rst_edge || n < 4) begin
      chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);
      chk("hs_vs_blank_sync", {28'd0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N}, 32'b1100);
      chk("frame_start", 32'(FRAME_START), 32'd0);
    end else begin
      k = (n - 4) / 2;
      h = k % H_TOT;
      v = (k / H_TOT) % V_TOT;
      vis = visible(k);
      c = vis ? colour_of(k) : 3'b000;
      chk("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}});
      chk("hs_vs_blank_sync", {28'd0, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N},
          {28'd0, !(h >= 656 && h < 752), !(v >= V_ACT + V_FPL && v < V_ACT + V_FPL + V_SYL),
           vis, 1'b0});
      chk("frame_start", 32'(FRAME_START), 32'((n % 2 == 0) && (k % FRAME_T == 0)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);

    RESET = 1'b1;
    repeat (10) step();
    RESET = 1'b0;

    // Two full frames and into the third, up to counter (300, 5).
    while (n < 2 * (2 * FRAME_T + 5 * H_TOT + 300) + 1) step();

    RESET = 1'b1;
    repeat (3) step();
    TEST_MODE = 1'b1;
    RESET = 1'b0;
    repeat (3000) step();

    chk("frame_start_count", 32'(fs_seen), 32'd4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
